// File: rtl/vga_console_scheduler.sv
// vga_console_scheduler
//   Arbitrates two byte requesters into a character FIFO and drains the FIFO
//   into the console as one-cycle font_we pulses. Two consecutive pulses are
//   always separated by at least GAP font_we-low cycles, and nothing is
//   issued while scroll is high.
//
// Ports
//   HCLK, HRESETn           clock, async active-low reset
//   reqN_valid/data/ready   requester N handshake (N = 0,1), ready is comb
//   scroll                  stall draining while high
//   font_we, font_data      registered write strobe and character code
//   fifo_level              current FIFO occupancy
//   busy                    FIFO non-empty or drain FSM not idle
module vga_console_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP        = 1
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        req0_valid,
  input  logic [7:0]                  req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [7:0]                  req1_data,
  output logic                        req1_ready,
  input  logic                        scroll,
  output logic                        font_we,
  output logic [7:0]                  font_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_L = FIFO_DEPTH[AW:0];
  localparam logic [3:0]      GAP_LD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

  state_t                     state, state_nxt;
  logic [3:0]                 gap_cnt, gap_cnt_nxt;
  logic                       last_winner;
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                level;
  logic                       gnt0, gnt1, full, push, pop, drain_ok;
  logic [7:0]                 push_data;
  logic                       font_we_nxt;
  logic [7:0]                 font_data_nxt;

  // ---------------- arbitration ----------------
  // With both valid, the grant goes to whoever did not win last.
  assign gnt0 = req0_valid & (~req1_valid | last_winner);
  assign gnt1 = req1_valid & (~req0_valid | ~last_winner);
  assign full = (level == DEPTH_L);

  // Ready is forced low during reset so nothing looks accepted.
  assign req0_ready = HRESETn & ~full & gnt0;
  assign req1_ready = HRESETn & ~full & gnt1;
  assign push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign push_data  = gnt0 ? req0_data : req1_data;

  // ---------------- drain eligibility ----------------
  // A pop may happen from IDLE, straight out of ISSUE when GAP is zero, or
  // on the last HOLD cycle; the latter makes the low run exactly GAP cycles.
  always_comb begin
    drain_ok = 1'b0;
    case (state)
      IDLE:    drain_ok = 1'b1;
      ISSUE:   drain_ok = (GAP == 0);
      HOLD:    drain_ok = (gap_cnt == 4'd0);
      default: drain_ok = 1'b0;
    endcase
  end

  assign pop = drain_ok & (level != '0) & ~scroll;

  // ---------------- FIFO ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      last_winner <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        last_winner <= gnt1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // ---------------- drain FSM: state register ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      gap_cnt   <= 4'd0;
      font_we   <= 1'b0;
      font_data <= 8'h00;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      font_we   <= font_we_nxt;
      font_data <= font_data_nxt;
    end
  end

  // ---------------- drain FSM: next state ----------------
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: if (pop) state_nxt = ISSUE;
      ISSUE: begin
        if (pop)          state_nxt = ISSUE;
        else if (GAP > 0) begin
          state_nxt   = HOLD;
          gap_cnt_nxt = GAP_LD;
        end else          state_nxt = IDLE;
      end
      HOLD: begin
        if (gap_cnt == 4'd0) state_nxt = pop ? ISSUE : IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- drain FSM: outputs ----------------
  always_comb begin
    font_we_nxt   = pop;
    font_data_nxt = pop ? mem[rd_ptr] : 8'h00;
  end

  assign busy       = (level != '0) | (state != IDLE);
  assign fifo_level = level;

endmodule

// File: tb/tb_vga_console_scheduler.sv
// Bench for vga_console_scheduler: a queue-based model checked every cycle
// against the GAP=1 instance, plus literal expectations on the pulse trains.
// A second instance with GAP=0 shares the stimulus for the back-to-back case.
module tb_vga_console_scheduler;

  localparam int DEPTH = 8;
  localparam int GAP   = 1;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, scroll = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, font_we, busy;
  logic [7:0] font_data;
  logic [3:0] fifo_level;
  logic       g_r0, g_r1, g_we, g_busy;
  logic [7:0] g_data;
  logic [3:0] g_level;

  always #5 HCLK = ~HCLK;

  vga_console_scheduler #(.FIFO_DEPTH(DEPTH), .GAP(GAP)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .scroll(scroll), .font_we(font_we), .font_data(font_data),
    .fifo_level(fifo_level), .busy(busy));

  vga_console_scheduler #(.FIFO_DEPTH(DEPTH), .GAP(0)) u_g0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(g_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(g_r1),
    .scroll(scroll), .font_we(g_we), .font_data(g_data),
    .fifo_level(g_level), .busy(g_busy));

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pulses are issued from a queue whenever scroll is low and the strobe has
  // been low for at least GAP cycles (GAP=0 lets a pulse follow a pulse).
  logic [7:0] mq[$];
  bit         m_lw = 1'b1, m_we = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         lowrun = 31;   // consecutive low-strobe cycles, saturating

  function automatic bit m_rdy0();
    return HRESETn && (mq.size() < DEPTH) && req0_valid && (!req1_valid || m_lw);
  endfunction
  function automatic bit m_rdy1();
    return HRESETn && (mq.size() < DEPTH) && req1_valid && (!req0_valid || !m_lw);
  endfunction

  initial begin
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        mq.delete(); m_lw = 1'b1; m_we = 1'b0; m_data = 8'h00; lowrun = 31;
      end else begin
        bit a0, a1, dopop;
        a0 = m_rdy0();
        a1 = m_rdy1();
        dopop = (mq.size() > 0) && !scroll && (m_we ? (GAP == 0) : (lowrun >= GAP));
        if (dopop) begin
          m_data = mq.pop_front(); m_we = 1'b1; lowrun = 0;
        end else begin
          lowrun = m_we ? 1 : ((lowrun < 31) ? lowrun + 1 : 31);
          m_we = 1'b0; m_data = 8'h00;
        end
        if (a0) begin mq.push_back(req0_data); m_lw = 1'b0; end
        if (a1) begin mq.push_back(req1_data); m_lw = 1'b1; end
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge HCLK);
      chk("font_we",    font_we,    m_we);
      chk("font_data",  font_data,  m_data);
      chk("fifo_level", fifo_level, mq.size());
      chk("req0_ready", req0_ready, m_rdy0());
      chk("req1_ready", req1_ready, m_rdy1());
      chk("busy",       busy,       (mq.size() > 0) || m_we || (lowrun <= GAP));
    end
  end

  // ---------------- pulse logs ----------------
  int         p_cyc[$], g_cyc[$];
  logic [7:0] p_dat[$], g_dat[$];

  initial forever begin @(posedge HCLK); cyc++; end
  initial forever begin
    @(negedge HCLK);
    if (font_we) begin p_cyc.push_back(cyc); p_dat.push_back(font_data); end
    if (g_we)    begin g_cyc.push_back(cyc); g_dat.push_back(g_data);    end
  end

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic clr_logs();
    p_cyc.delete(); p_dat.delete(); g_cyc.delete(); g_dat.delete();
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; scroll = 1'b0;
    tick(); tick();
    HRESETn = 1'b1;
    clr_logs();
  endtask

  task automatic push0(input logic [7:0] d);
    req0_valid = 1'b1; req0_data = d;
    tick();
    req0_valid = 1'b0;
  endtask

  task automatic chk_train(input string name, input logic [7:0] exp_q[$], input int period);
    chk({name, "_count"}, p_dat.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < p_dat.size(); k++) begin
      chk({name, "_data"}, p_dat[k], exp_q[k]);
      if (k > 0) chk({name, "_space"}, p_cyc[k] - p_cyc[k-1], period);
    end
  endtask

  initial begin
    logic [7:0] exq[$];
    int nacc;
    bit a0, a1;

    #2 HRESETn = 1'b0;
    req0_valid = 1'b1;
    tick();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_level",  fifo_level, 0);
    chk("rst_we",     font_we,    0);
    chk("rst_busy",   busy,       0);

    // single byte, accepted on the first edge after release
    req0_data = 8'h41;
    tick();
    HRESETn = 1'b1;
    clr_logs();
    tick();                       // edge N: accept
    req0_valid = 1'b0;
    chk("t1_level_n", fifo_level, 1);
    tick();                       // edge N+1
    chk("t1_we_n1",   font_we,   1);
    chk("t1_data_n1", font_data, 8'h41);
    tick();                       // edge N+2
    chk("t1_we_n2",    font_we,    0);
    chk("t1_level_n2", fifo_level, 0);
    tick();
    chk("t1_busy_n3", busy, 0);
    chk("t1_pulses",  p_dat.size(), 1);

    // round robin with both requesters valid
    do_reset();
    req0_data = 8'h10; req1_data = 8'h20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK); a0 = req0_ready; a1 = req1_ready;
      tick();
      if (a0) req0_data++;
      if (a1) req1_data++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (20) tick();
    exq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    chk_train("rr", exq, GAP + 1);

    // full FIFO under scroll
    do_reset();
    scroll = 1'b1;
    nacc = 0;
    req0_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req0_data = 8'(8'h30 + nacc);
      @(negedge HCLK); a0 = req0_ready;
      tick();
      if (a0) nacc++;
    end
    req1_valid = 1'b1;
    @(negedge HCLK);
    chk("full_acc",    nacc,       8);
    chk("full_level",  fifo_level, 8);
    chk("full_rdy0",   req0_ready, 0);
    chk("full_rdy1",   req1_ready, 0);
    chk("full_pulses", p_dat.size(), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; scroll = 1'b0;
    repeat (24) tick();
    exq.delete();
    for (int i = 0; i < 8; i++) exq.push_back(8'(8'h30 + i));
    chk_train("full", exq, GAP + 1);

    // push and pop on the same edge
    do_reset();
    scroll = 1'b1;
    push0(8'h50); push0(8'h51);
    chk("pp_level_pre", fifo_level, 2);
    scroll = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h52;
    tick();
    req0_valid = 1'b0;
    chk("pp_level", fifo_level, 2);
    chk("pp_we",    font_we,    1);
    repeat (10) tick();
    exq = '{8'h50, 8'h51, 8'h52};
    chk_train("pp", exq, GAP + 1);

    // GAP=0 instance: three queued bytes drain on consecutive cycles
    do_reset();
    scroll = 1'b1;
    push0(8'h60); push0(8'h61); push0(8'h62);
    clr_logs();
    scroll = 1'b0;
    repeat (8) tick();
    chk("g0_count", g_dat.size(), 3);
    for (int k = 0; k < 3 && k < g_dat.size(); k++) begin
      chk("g0_data", g_dat[k], 8'h60 + k);
      if (k > 0) chk("g0_space", g_cyc[k] - g_cyc[k-1], 1);
    end

    // reset mid-run with bytes queued
    do_reset();
    scroll = 1'b1;
    for (int i = 0; i < 5; i++) push0(8'(8'h70 + i));
    scroll = 1'b0;
    tick();
    chk("mr_we_before", font_we, 1);
    req0_valid = 1'b1;
    HRESETn = 1'b0;
    #1;
    chk("mr_we",    font_we,    0);
    chk("mr_data",  font_data,  0);
    chk("mr_level", fifo_level, 0);
    chk("mr_busy",  busy,       0);
    chk("mr_rdy0",  req0_ready, 0);
    tick(); tick();
    req0_valid = 1'b0;
    HRESETn = 1'b1;
    clr_logs();
    repeat (10) tick();
    chk("mr_quiet", p_dat.size(), 0);
    push0(8'h7A);
    repeat (5) tick();
    exq = '{8'h7A};
    chk_train("mr_new", exq, GAP + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
